mips_fetch_mem_wb: RTL and testbench
====================================

# mips_fetch_mem_wb

Fetch, data-memory and write-back stages of the multi-cycle MIPS processor, grouped into one clocked block. Each stage is started by a one-cycle "go" token from the sequencer and returns a one-cycle "done" token with its result. The block holds the 16-word instruction ROM, the 256-word data memory and the 64-entry register file. The ALU and decode stages sit outside and drive this block's stage inputs.

## Interface
Parameters:
- IMEM_AW, 4, instruction ROM address width (16 words)
- DMEM_AW, 8, data memory address width (256 words)
- RF_AW, 6, register file address width (64 registers)
- DW, 32, data/instruction width

Ports:
- clock  in  1  single clock; all state updates on rising edge
- start  in  1  reset, asynchronous, active-high
- pc  in  IMEM_AW  instruction address
- stage1  in  1  fetch go token
- cur_instruction  out  DW  fetched instruction
- stage2  out  1  fetch done token
- mem_write  in  1  data memory write enable
- mem_read  in  1  data memory read enable
- mem_address  in  DMEM_AW  data memory word address
- mem_wdata  in  DW  store data
- mem_rdata  out  DW  load data
- stage4  in  1  memory go token
- stage5  out  1  memory done token
- control_write_back  in  1  register write enable
- wb_address  in  RF_AW  destination register
- wb_data  in  DW  write-back value
- wb_go  in  1  write-back go token
- wb_done  out  1  write-back done token
- rf_raddr  in  RF_AW  register file read address, for operand and debug reads
- rf_rdata  out  DW  combinational register read

## Operation
- Reset (start=1): all done tokens are 0. cur_instruction=0 and mem_rdata=0. Every data memory word and every register is 0. The ROM is constant and is not affected by reset.
- ROM contents: word i = 32'h8C00_0000 + i, for i = 0..15.
- Fetch: on a clock edge with stage1=1, cur_instruction <= ROM[pc] and stage2 <= 1. Otherwise stage2 <= 0 and cur_instruction holds its value.
- Memory: on a clock edge with stage4=1:
  - If mem_write=1, dmem[mem_address] <= mem_wdata.
  - If mem_read=1, mem_rdata <= dmem[mem_address] using the pre-write value (read-before-write when mem_read and mem_write are both 1).
  - If mem_read=0, mem_rdata holds its value.
  - stage5 <= 1 even when both enables are 0.
  - With stage4=0, stage5 <= 0 and memory is untouched.
- Write-back: on a clock edge with wb_go=1:
  - If control_write_back=1 and wb_address != 0, rf[wb_address] <= wb_data. Register 0 is hardwired to zero and writes to it are dropped.
  - wb_done <= 1.
  - With wb_go=0, wb_done <= 0.
- rf_rdata = rf[rf_raddr], combinational. Address 0 always reads 0.
- The three stages are independent. Several go tokens in one cycle are all serviced in parallel.

## Timing
- Latency is exactly 1 clock from go to done and result for every stage. Results are valid in the same cycle that done is high and are held until the next accepted go.
- A go held high for N cycles gives N accepted operations and N consecutive done cycles.
- A register write is visible on rf_rdata in the cycle after the edge that accepts it.
- Reset asserted mid-operation clears done and results immediately, without waiting for a clock edge. An operation accepted on the edge where start deasserts proceeds normally.
- Address wrap: pc, mem_address and wb_address use their full width with no out-of-range case.

## Structure
- Package mips_pkg holds IMEM_AW, DMEM_AW, RF_AW, DW and the ROM init constant base (32'h8C00_0000).
- Sub-module mips_regfile holds the 64x32 register file: write port, one combinational read port, r0 hardwired to zero, async reset.
- Fetch and memory logic stay inline in the top module.

## Test plan
- Reset: start=1 with stage1=stage4=wb_go=1 -> stage2=stage5=wb_done=0, cur_instruction=0, rf_rdata=0 for every address.
- Fetch: pc=4'd3, stage1 pulse -> next cycle stage2=1, cur_instruction=32'h8C00_0003. Then stage2=0 and the value is held.
- Store then load: write 32'hDEAD_BEEF at address 8'hFF, then read 8'hFF -> stage5 pulses each time, mem_rdata=32'hDEAD_BEEF. A read of address 8'h00 returns 0.
- Simultaneous read and write: address 8'h10 holds 32'h1, then mem_read=mem_write=1 with mem_wdata=32'h2 -> mem_rdata=32'h1. A following read returns 32'h2.
- Write-back: wb_address=6'd63, wb_data=32'h1234_5678, control_write_back=1 -> wb_done=1 and rf[63]=32'h1234_5678. Write 32'hFFFF_FFFF to r0 -> rf_rdata(0)=0. With control_write_back=0, wb_done still pulses and rf is unchanged.
- Reset mid-operation: assert start in the cycle after stage4 while stage5=1 -> stage5 drops to 0 asynchronously and dmem reads 0 after start is released.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared widths and ROM contents for the fetch / memory / write-back block.
// Imported by mips_fetch_mem_wb and mips_regfile.
package mips_pkg;

    localparam int IMEM_AW = 4;
    localparam int DMEM_AW = 8;
    localparam int RF_AW   = 6;
    localparam int DW      = 32;

    localparam logic [31:0] ROM_BASE = 32'h8C00_0000;

    // ROM word i is the base constant plus its own index.
    function automatic logic [31:0] rom_word(input logic [31:0] idx);
        return ROM_BASE + idx;
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// Register file: one write port, one combinational read port, r0 reads zero.
// Ports: clock, start (async reset), we/waddr/wdata write, raddr/rdata read.
module mips_regfile
    import mips_pkg::*;
#(
    parameter int AW = 6,
    parameter int W  = 32
) (
    input  logic          clock,
    input  logic          start,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clock or posedge start) begin
        if (start) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    // r0 is forced on the read side so a stale entry can never leak out.
    assign rdata = (raddr == '0) ? '0 : mem[raddr];

endmodule

// File: rtl/mips_fetch_mem_wb.sv
// Fetch, data-memory and write-back stages of the multi-cycle MIPS core.
// Ports: clock/start, fetch (pc, stage1 -> cur_instruction, stage2),
// memory (stage4, mem_* -> mem_rdata, stage5), write-back (wb_go, wb_* ->
// wb_done), register read (rf_raddr -> rf_rdata).
module mips_fetch_mem_wb
    import mips_pkg::*;
#(
    parameter int IMEM_AW = mips_pkg::IMEM_AW,
    parameter int DMEM_AW = mips_pkg::DMEM_AW,
    parameter int RF_AW   = mips_pkg::RF_AW,
    parameter int DW      = mips_pkg::DW
) (
    input  logic               clock,
    input  logic               start,
    input  logic [IMEM_AW-1:0] pc,
    input  logic               stage1,
    output logic [DW-1:0]      cur_instruction,
    output logic               stage2,
    input  logic               mem_write,
    input  logic               mem_read,
    input  logic [DMEM_AW-1:0] mem_address,
    input  logic [DW-1:0]      mem_wdata,
    output logic [DW-1:0]      mem_rdata,
    input  logic               stage4,
    output logic               stage5,
    input  logic               control_write_back,
    input  logic [RF_AW-1:0]   wb_address,
    input  logic [DW-1:0]      wb_data,
    input  logic               wb_go,
    output logic               wb_done,
    input  logic [RF_AW-1:0]   rf_raddr,
    output logic [DW-1:0]      rf_rdata
);

    logic [DW-1:0] rom_q;
    logic [DW-1:0] dmem [2**DMEM_AW];

    // The ROM is pure constant logic, so reset cannot disturb it.
    assign rom_q = DW'(rom_word(32'(pc)));

    always_ff @(posedge clock or posedge start) begin
        if (start) begin
            stage2          <= 1'b0;
            cur_instruction <= '0;
        end else begin
            stage2 <= stage1;
            if (stage1) begin
                cur_instruction <= rom_q;
            end
        end
    end

    // Read samples the old word even when a write to it lands this edge.
    always_ff @(posedge clock or posedge start) begin
        if (start) begin
            stage5    <= 1'b0;
            mem_rdata <= '0;
            for (int i = 0; i < 2**DMEM_AW; i++) begin
                dmem[i] <= '0;
            end
        end else begin
            stage5 <= stage4;
            if (stage4 && mem_read) begin
                mem_rdata <= dmem[mem_address];
            end
            if (stage4 && mem_write) begin
                dmem[mem_address] <= mem_wdata;
            end
        end
    end

    always_ff @(posedge clock or posedge start) begin
        if (start) begin
            wb_done <= 1'b0;
        end else begin
            wb_done <= wb_go;
        end
    end

    mips_regfile #(
        .AW (RF_AW),
        .W  (DW)
    ) u_rf (
        .clock (clock),
        .start (start),
        .we    (wb_go && control_write_back),
        .waddr (wb_address),
        .wdata (wb_data),
        .raddr (rf_raddr),
        .rdata (rf_rdata)
    );

endmodule

// File: tb/tb_mips_fetch_mem_wb.sv
// Self-checking bench for mips_fetch_mem_wb: directed literal cases plus
// randomized traffic compared every cycle against a behavioural model.
module tb_mips_fetch_mem_wb;

    logic        clock = 1'b0;
    logic        start = 1'b1;
    logic [3:0]  pc = '0;
    logic        stage1 = 1'b0;
    logic [31:0] cur_instruction;
    logic        stage2;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [7:0]  mem_address = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        stage4 = 1'b0;
    logic        stage5;
    logic        control_write_back = 1'b0;
    logic [5:0]  wb_address = '0;
    logic [31:0] wb_data = '0;
    logic        wb_go = 1'b0;
    logic        wb_done;
    logic [5:0]  rf_raddr = '0;
    logic [31:0] rf_rdata;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    always #5 clock = ~clock;

    mips_fetch_mem_wb dut (
        .clock              (clock),
        .start              (start),
        .pc                 (pc),
        .stage1             (stage1),
        .cur_instruction    (cur_instruction),
        .stage2             (stage2),
        .mem_write          (mem_write),
        .mem_read           (mem_read),
        .mem_address        (mem_address),
        .mem_wdata          (mem_wdata),
        .mem_rdata          (mem_rdata),
        .stage4             (stage4),
        .stage5             (stage5),
        .control_write_back (control_write_back),
        .wb_address         (wb_address),
        .wb_data            (wb_data),
        .wb_go              (wb_go),
        .wb_done            (wb_done),
        .rf_raddr           (rf_raddr),
        .rf_rdata           (rf_rdata)
    );

    // Behavioural model: plain arrays and the stage rules.
    logic [31:0] m_dm [256];
    logic [31:0] m_rf [64];
    logic [31:0] m_ci = '0;
    logic [31:0] m_rd = '0;
    logic        m_s2 = 0;
    logic        m_s5 = 0;
    logic        m_wbd = 0;

    always @(posedge clock or posedge start) begin
        if (start) begin
            m_s2 = 0; m_s5 = 0; m_wbd = 0;
            m_ci = '0; m_rd = '0;
            for (int i = 0; i < 256; i++) m_dm[i] = '0;
            for (int i = 0; i < 64; i++) m_rf[i] = '0;
        end else begin
            m_s2 = stage1;
            if (stage1) m_ci = 32'h8C00_0000 + 32'(pc);
            m_s5 = stage4;
            if (stage4 && mem_read) m_rd = m_dm[mem_address];
            if (stage4 && mem_write) m_dm[mem_address] = mem_wdata;
            m_wbd = wb_go;
            if (wb_go && control_write_back && wb_address != 0)
                m_rf[wb_address] = wb_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("model_stage2", 32'(stage2), 32'(m_s2));
            check("model_instr", cur_instruction, m_ci);
            check("model_stage5", 32'(stage5), 32'(m_s5));
            check("model_rdata", mem_rdata, m_rd);
            check("model_wbdone", 32'(wb_done), 32'(m_wbd));
            check("model_rf", rf_rdata, m_rf[rf_raddr]);
        end
    end

    task automatic edge_();
        @(posedge clock);
        #2;
    endtask

    task automatic do_fetch(input logic [3:0] a);
        pc = a; stage1 = 1;
        edge_();
        stage1 = 0;
    endtask

    task automatic do_mem(input logic w, input logic r, input logic [7:0] a,
                          input logic [31:0] d);
        mem_write = w; mem_read = r; mem_address = a; mem_wdata = d;
        stage4 = 1;
        edge_();
        stage4 = 0; mem_write = 0; mem_read = 0;
    endtask

    task automatic do_wb(input logic en, input logic [5:0] a,
                         input logic [31:0] d);
        control_write_back = en; wb_address = a; wb_data = d; wb_go = 1;
        edge_();
        wb_go = 0; control_write_back = 0;
    endtask

    initial begin
        stage1 = 1; stage4 = 1; wb_go = 1;
        edge_();
        edge_();
        chk_en = 1;
        check("rst_stage2", 32'(stage2), 32'h0);
        check("rst_stage5", 32'(stage5), 32'h0);
        check("rst_wbdone", 32'(wb_done), 32'h0);
        check("rst_instr", cur_instruction, 32'h0);
        check("rst_rdata", mem_rdata, 32'h0);
        for (int i = 0; i < 64; i++) begin
            rf_raddr = 6'(i);
            #0.1;
            check("rst_rf", rf_rdata, 32'h0);
        end
        stage1 = 0; stage4 = 0; wb_go = 0;
        start = 0;
        edge_();

        do_fetch(4'd3);
        check("fetch_done", 32'(stage2), 32'h1);
        check("fetch_instr", cur_instruction, 32'h8C00_0003);
        edge_();
        check("fetch_drop", 32'(stage2), 32'h0);
        check("fetch_hold", cur_instruction, 32'h8C00_0003);
        do_fetch(4'd15);
        check("fetch_wrap", cur_instruction, 32'h8C00_000F);

        do_mem(1, 0, 8'hFF, 32'hDEAD_BEEF);
        check("store_done", 32'(stage5), 32'h1);
        do_mem(0, 1, 8'hFF, 32'h0);
        check("load_done", 32'(stage5), 32'h1);
        check("load_ff", mem_rdata, 32'hDEAD_BEEF);
        do_mem(0, 1, 8'h00, 32'h0);
        check("load_00", mem_rdata, 32'h0);
        do_mem(1, 0, 8'h10, 32'h1);
        do_mem(1, 1, 8'h10, 32'h2);
        check("rbw_old", mem_rdata, 32'h1);
        do_mem(0, 0, 8'h10, 32'h0);
        check("noop_done", 32'(stage5), 32'h1);
        check("noop_hold", mem_rdata, 32'h1);
        do_mem(0, 1, 8'h10, 32'h0);
        check("rbw_new", mem_rdata, 32'h2);

        rf_raddr = 6'd63;
        do_wb(1, 6'd63, 32'h1234_5678);
        check("wb_done", 32'(wb_done), 32'h1);
        check("wb_r63", rf_rdata, 32'h1234_5678);
        rf_raddr = 6'd0;
        do_wb(1, 6'd0, 32'hFFFF_FFFF);
        check("wb_r0", rf_rdata, 32'h0);
        rf_raddr = 6'd63;
        do_wb(0, 6'd63, 32'hAAAA_5555);
        check("wb_nowr_done", 32'(wb_done), 32'h1);
        check("wb_nowr_rf", rf_rdata, 32'h1234_5678);

        do_mem(1, 0, 8'h20, 32'h0000_00AB);
        check("mid_s5_before", 32'(stage5), 32'h1);
        start = 1;
        #1;
        check("mid_s5_async", 32'(stage5), 32'h0);
        check("mid_rdata_async", mem_rdata, 32'h0);
        check("mid_instr_async", cur_instruction, 32'h0);
        edge_();
        start = 0;
        do_mem(0, 1, 8'h20, 32'h0);
        check("mid_dmem_clr", mem_rdata, 32'h0);
        check("mid_rf_clr", rf_rdata, 32'h0);

        // Random traffic; a small address pool forces reuse and hazards.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock);
            #2;
            start = ($urandom_range(0, 99) == 0);
            pc = 4'($urandom);
            stage1 = 1'($urandom);
            stage4 = 1'($urandom);
            mem_write = 1'($urandom);
            mem_read = 1'($urandom);
            mem_address = ($urandom_range(0, 1) == 0) ?
                8'($urandom_range(0, 7)) : 8'($urandom);
            mem_wdata = $urandom;
            wb_go = 1'($urandom);
            control_write_back = 1'($urandom);
            wb_address = 6'($urandom_range(0, 7));
            wb_data = $urandom;
            rf_raddr = 6'($urandom_range(0, 7));
        end
        edge_();
        start = 0;
        edge_();
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
